// File: rtl/dpd_delay_est_pkg.sv
// -----------------------------------------------------------------------------
// package_dpd
//   Shared types and constants for the DPD loop-delay estimator.
//   DLY_NLAG : lags searched (0..DLY_NLAG-1)
//   DLY_WIN  : correlation length in samples
//   DLY_AW   : accumulator / peak width (sample width + 9)
//   dly_state_t : measurement FSM states
// -----------------------------------------------------------------------------
package package_dpd;

   localparam int DLY_W    = 20;
   localparam int DLY_NLAG = 64;
   localparam int DLY_WIN  = 256;
   localparam int DLY_LW   = $clog2(DLY_NLAG);
   localparam int DLY_AW   = DLY_W + 9;

   typedef logic signed [DLY_W-1:0] s20_t;
   typedef logic        [DLY_LW-1:0] u6_t;

   typedef enum logic [2:0] {
      IDLE,
      FILL,
      ACC,
      SCAN,
      DONE
   } dly_state_t;

endpackage

// File: rtl/dpd_xcorr_lane.sv
// -----------------------------------------------------------------------------
// dpd_xcorr_lane
//   One lag of the sign-reference cross-correlator.
//   acc += s(ref_i)*fb_i + s(ref_q)*fb_q while en, with s(x) = -1 for x<0 else +1.
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   clr               clear accumulator (start of a measurement)
//   en                accumulate this cycle
//   ref_sign_i/q      sign bits of the delayed reference sample for this lag
//   fb_i/q            PA feedback sample (signed, W bits)
//   acc               running correlation (signed, AW bits)
// -----------------------------------------------------------------------------
module dpd_xcorr_lane
   import package_dpd::*;
#(
   parameter int W  = DLY_W,
   parameter int AW = DLY_AW
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clr,
   input  logic                 en,
   input  logic                 ref_sign_i,
   input  logic                 ref_sign_q,
   input  logic signed [W-1:0]  fb_i,
   input  logic signed [W-1:0]  fb_q,
   output logic signed [AW-1:0] acc
);

   // One bit wider than a single product so that +2^(W-1) + +2^(W-1) cannot wrap.
   logic signed [W+1:0] prod_i;
   logic signed [W+1:0] prod_q;
   logic signed [W+1:0] term;

   always_comb begin
      prod_i = ref_sign_i ? -((W+2)'(fb_i)) : (W+2)'(fb_i);
      prod_q = ref_sign_q ? -((W+2)'(fb_q)) : (W+2)'(fb_q);
      term   = prod_i + prod_q;
   end

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         acc <= '0;
      end else if (en) begin
         acc <= acc + AW'(term);
      end
   end

endmodule

// File: rtl/dpd_delay_est.sv
// -----------------------------------------------------------------------------
// dpd_delay_est
//   Measures the TX->PA->ADC loop delay by sign-reference cross-correlation of
//   the training reference against the PA feedback over lags 0..NLAG-1, then
//   publishes the winning lag and a reference stream re-aligned to it.
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   start               1-cycle pulse, begins a measurement (ignored while busy)
//   ref_i/q             TX reference (signed W)
//   fb_i/q              PA feedback (signed W)
//   busy                high from start accept through DONE
//   dly_valid           1-cycle pulse, dly/peak updated
//   dly                 measured lag in samples, held until next result
//   peak                correlation at dly (W+9 bits)
//   ref_al_i/q          reference delayed by dly+1 cycles (registered tap)
//   fb_inv              (DPD_DELAY_EST_ABS_EN only) sign of correlation at dly
// Configuration:
//   DPD_DELAY_EST_ABS_EN  scan on |acc| so an inverted feedback still locks;
//                         peak becomes |acc| and fb_inv is added.
// -----------------------------------------------------------------------------
module dpd_delay_est
   import package_dpd::*;
#(
   parameter int W    = DLY_W,
   parameter int NLAG = DLY_NLAG,
   parameter int WIN  = DLY_WIN,
   parameter int LW   = $clog2(NLAG)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic signed [W-1:0] ref_i,
   input  logic signed [W-1:0] ref_q,
   input  logic signed [W-1:0] fb_i,
   input  logic signed [W-1:0] fb_q,
   output logic                busy,
   output logic                dly_valid,
   output logic [LW-1:0]       dly,
   output logic [W+8:0]        peak,
   output logic signed [W-1:0] ref_al_i,
`ifdef DPD_DELAY_EST_ABS_EN
   output logic signed [W-1:0] ref_al_q,
   output logic                fb_inv
`else
   output logic signed [W-1:0] ref_al_q
`endif
);

   localparam int AW = W + 9;
   localparam int CW = $clog2((WIN > NLAG) ? WIN : NLAG);

   dly_state_t          state;
   logic [CW-1:0]       cnt;

   // Tap 0 is the live input; tap k>0 comes from dl[k-1].
   logic signed [W-1:0] dl_i  [NLAG-1];
   logic signed [W-1:0] dl_q  [NLAG-1];
   logic signed [W-1:0] tap_i [NLAG];
   logic signed [W-1:0] tap_q [NLAG];

   logic signed [AW-1:0] acc [NLAG];
   logic                 clr;
   logic                 acc_en;

   logic signed [AW-1:0] scan_acc;
`ifdef DPD_DELAY_EST_ABS_EN
   logic [AW-1:0]        scan_val;
   logic [AW-1:0]        best;
   logic [AW-1:0]        nxt_best;
   logic                 best_neg;
   logic                 nxt_neg;
`else
   logic signed [AW-1:0] scan_val;
   logic signed [AW-1:0] best;
   logic signed [AW-1:0] nxt_best;
`endif
   logic [LW-1:0]        best_idx;
   logic [LW-1:0]        nxt_idx;
   logic                 take;

   // ---------------- reference delay line ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned k = 0; k < NLAG-1; k++) begin
            dl_i[k] <= '0;
            dl_q[k] <= '0;
         end
      end else begin
         dl_i[0] <= ref_i;
         dl_q[0] <= ref_q;
         for (int unsigned k = 1; k < NLAG-1; k++) begin
            dl_i[k] <= dl_i[k-1];
            dl_q[k] <= dl_q[k-1];
         end
      end
   end

   always_comb begin
      tap_i[0] = ref_i;
      tap_q[0] = ref_q;
      for (int unsigned k = 1; k < NLAG; k++) begin
         tap_i[k] = dl_i[k-1];
         tap_q[k] = dl_q[k-1];
      end
   end

   // ---------------- correlator lanes ----------------
   assign clr    = (state == IDLE) && start;
   assign acc_en = (state == ACC);

   for (genvar k = 0; k < NLAG; k++) begin : g_lane
      dpd_xcorr_lane #(.W(W), .AW(AW)) u_lane (
         .clk        (clk),
         .reset      (reset),
         .clr        (clr),
         .en         (acc_en),
         .ref_sign_i (tap_i[k][W-1]),
         .ref_sign_q (tap_q[k][W-1]),
         .fb_i       (fb_i),
         .fb_q       (fb_q),
         .acc        (acc[k])
      );
   end

   // ---------------- argmax scanner ----------------
   // Lane 0 seeds the running best; later lanes must be strictly larger so ties keep the lower lag.
   always_comb begin
      scan_acc = acc[cnt[LW-1:0]];
`ifdef DPD_DELAY_EST_ABS_EN
      scan_val = scan_acc[AW-1] ? $unsigned(-scan_acc) : $unsigned(scan_acc);
`else
      scan_val = scan_acc;
`endif
      take     = (cnt == '0) || (scan_val > best);
      nxt_best = take ? scan_val : best;
      nxt_idx  = take ? cnt[LW-1:0] : best_idx;
`ifdef DPD_DELAY_EST_ABS_EN
      nxt_neg  = take ? scan_acc[AW-1] : best_neg;
`endif
   end

   // ---------------- FSM ----------------
   // The last SCAN compare is folded into the DONE-entry write so dly/peak and dly_valid appear together in DONE.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         busy      <= 1'b0;
         dly_valid <= 1'b0;
         dly       <= '0;
         peak      <= '0;
         best      <= '0;
         best_idx  <= '0;
`ifdef DPD_DELAY_EST_ABS_EN
         best_neg  <= 1'b0;
         fb_inv    <= 1'b0;
`endif
      end else begin
         dly_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  state <= FILL;
                  cnt   <= '0;
                  busy  <= 1'b1;
               end
            end
            FILL: begin
               if (cnt == CW'(NLAG-1)) begin
                  cnt   <= '0;
                  state <= ACC;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ACC: begin
               if (cnt == CW'(WIN-1)) begin
                  cnt   <= '0;
                  state <= SCAN;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            SCAN: begin
               best     <= nxt_best;
               best_idx <= nxt_idx;
`ifdef DPD_DELAY_EST_ABS_EN
               best_neg <= nxt_neg;
`endif
               if (cnt == CW'(NLAG-1)) begin
                  cnt       <= '0;
                  state     <= DONE;
                  dly       <= nxt_idx;
                  peak      <= nxt_best;
                  dly_valid <= 1'b1;
`ifdef DPD_DELAY_EST_ABS_EN
                  fb_inv    <= nxt_neg;
`endif
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // ---------------- aligned reference ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         ref_al_i <= '0;
         ref_al_q <= '0;
      end else begin
         ref_al_i <= tap_i[dly];
         ref_al_q <= tap_q[dly];
      end
   end

endmodule

// File: tb/tb_dpd_delay_est.sv
// -----------------------------------------------------------------------------
// tb_dpd_delay_est
//   Self-checking bench for dpd_delay_est. Random reference stimulus, feedback
//   formed as a delayed (optionally negated) copy, and a reference model that
//   computes every lag's correlation directly from the recorded sample history.
//   Define DPD_DELAY_EST_ABS_EN to exercise the magnitude-compare build.
// -----------------------------------------------------------------------------
module tb_dpd_delay_est;

   localparam int W    = 20;
   localparam int NLAG = 64;
   localparam int WIN  = 256;
   localparam int LW   = 6;
   localparam int AW   = W + 9;
   localparam int LAT  = 1 + NLAG + WIN + NLAG + 1;
   localparam int MAXC = 8192;

   logic                clk = 1'b0;
   logic                reset;
   logic                start;
   logic signed [W-1:0] ref_i, ref_q, fb_i, fb_q;
   logic                busy, dly_valid;
   logic [LW-1:0]       dly;
   logic [AW-1:0]       peak;
   logic signed [W-1:0] ref_al_i, ref_al_q;
`ifdef DPD_DELAY_EST_ABS_EN
   logic                fb_inv;
`endif

   always #5 clk = ~clk;

   dpd_delay_est #(.W(W), .NLAG(NLAG), .WIN(WIN), .LW(LW)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .ref_i     (ref_i),
      .ref_q     (ref_q),
      .fb_i      (fb_i),
      .fb_q      (fb_q),
      .busy      (busy),
      .dly_valid (dly_valid),
      .dly       (dly),
      .peak      (peak),
      .ref_al_i  (ref_al_i),
`ifdef DPD_DELAY_EST_ABS_EN
      .ref_al_q  (ref_al_q),
      .fb_inv    (fb_inv)
`else
      .ref_al_q  (ref_al_q)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;   // number of rising edges so far

   // Stimulus modes: 0 fb=0, 1 fb=ref delayed g_lag, 2 fb=-(ref delayed g_lag), 3 ref impulse at g_imp
   int g_mode = 0;
   int g_lag  = 0;
   int g_imp  = -1;

   // Inputs as sampled at edge n
   logic signed [W-1:0] h_ri [MAXC];
   logic signed [W-1:0] h_rq [MAXC];
   logic signed [W-1:0] h_fi [MAXC];
   logic signed [W-1:0] h_fq [MAXC];

   // Drive the inputs for the next edge, record them, advance one edge, settle.
   task automatic step(input bit st, input bit rst);
      int n;
      logic [15:0] u;
      logic signed [W-1:0] ri, rq, fi, fq;
      n = cyc + 1;
      if (n >= MAXC) begin
         $display("FAIL cycle_budget: edge %0d required below %0d", n, MAXC);
         $fatal(1, "cycle budget exhausted");
      end
      u  = 16'($urandom);
      ri = {u, 4'h0};
      u  = 16'($urandom);
      rq = {u, 4'h0};
      fi = '0;
      fq = '0;
      case (g_mode)
         1: if (n - g_lag >= 0) begin
               fi = h_ri[n - g_lag];
               fq = h_rq[n - g_lag];
            end
         2: if (n - g_lag >= 0) begin
               fi = -h_ri[n - g_lag];
               fq = -h_rq[n - g_lag];
            end
         3: begin
               ri = (n == g_imp) ? 20'sh7FFFF : '0;
               rq = '0;
            end
         default: ;
      endcase
      h_ri[n] = ri; h_rq[n] = rq; h_fi[n] = fi; h_fq[n] = fq;
      ref_i = ri; ref_q = rq; fb_i = fi; fb_q = fq;
      start = st;
      reset = rst;
      @(posedge clk);
      #1;
      cyc = n;
   endtask

   // Reference: correlate every lag over the WIN samples that follow the NLAG fill cycles after start.
   function automatic void ref_model(input int s, output int e_dly, output logic [AW-1:0] e_pk,
                                     output bit e_neg);
      longint acc, v, best;
      int     bi;
      bit     bneg;
      best = 0; bi = 0; bneg = 1'b0;
      for (int k = 0; k < NLAG; k++) begin
         acc = 0;
         for (int n = s + 1 + NLAG; n <= s + NLAG + WIN; n++) begin
            acc += (h_ri[n-k] < 0) ? -longint'(h_fi[n]) : longint'(h_fi[n]);
            acc += (h_rq[n-k] < 0) ? -longint'(h_fq[n]) : longint'(h_fq[n]);
         end
`ifdef DPD_DELAY_EST_ABS_EN
         v = (acc < 0) ? -acc : acc;
`else
         v = acc;
`endif
         if (k == 0 || v > best) begin
            best = v;
            bi   = k;
            bneg = (acc < 0);
         end
      end
      e_dly = bi;
      e_pk  = best[AW-1:0];
      e_neg = bneg;
   endfunction

   // Runs one measurement and reports what the DUT did; the caller checks.
   task automatic measure(input int restart_at, output int s, output int n_valid, output int lat,
                          output logic [LW-1:0] o_dly, output logic [AW-1:0] o_pk, output bit o_neg,
                          output bit busy_at_valid, output bit busy_after_any);
      int seen;
      seen = -1; n_valid = 0; lat = -1; o_dly = '0; o_pk = '0; o_neg = 1'b0;
      busy_at_valid = 1'b0; busy_after_any = 1'b0;
      s = cyc + 1;
      step(1'b1, 1'b0);
      for (int i = 1; i <= LAT + 40; i++) begin
         step(i == restart_at, 1'b0);
         if (dly_valid) begin
            n_valid++;
            if (seen < 0) begin
               seen          = cyc;
               lat           = cyc - s + 2;   // start cycle counts as cycle 1
               o_dly         = dly;
               o_pk          = peak;
               busy_at_valid = busy;
`ifdef DPD_DELAY_EST_ABS_EN
               o_neg         = fb_inv;
`endif
            end
         end
         if (seen >= 0 && cyc > seen && busy) busy_after_any = 1'b1;
         if (seen >= 0 && cyc >= seen + 4) break;
      end
   endtask

   task automatic test_reset();
      repeat (3) step(1'b0, 1'b1);
      n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
      n_checks++; if (dly_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", dly_valid); end
      n_checks++; if (dly !== '0)         begin n_fail++; $display("FAIL reset_dly got %0d want 0", dly); end
      n_checks++; if (peak !== '0)        begin n_fail++; $display("FAIL reset_peak got %h want 0", peak); end
      n_checks++; if (ref_al_i !== '0)    begin n_fail++; $display("FAIL reset_ref_al_i got %h want 0", ref_al_i); end
      n_checks++; if (ref_al_q !== '0)    begin n_fail++; $display("FAIL reset_ref_al_q got %h want 0", ref_al_q); end
      step(1'b0, 1'b0);
   endtask

   task automatic test_delay();
      int s, nv, lat, e_dly, lags[2];
      logic [LW-1:0] g_dly;
      logic [AW-1:0] g_pk, e_pk;
      bit g_neg, e_neg, bav, baa;
      lags[0] = 23;
      lags[1] = int'($urandom_range(1, NLAG-2));
      foreach (lags[t]) begin
         g_mode = 1; g_lag = lags[t];
         repeat (5) step(1'b0, 1'b0);
         measure(-1, s, nv, lat, g_dly, g_pk, g_neg, bav, baa);
         ref_model(s, e_dly, e_pk, e_neg);
         n_checks++; if (nv !== 1)      begin n_fail++; $display("FAIL delay_npulse lag %0d got %0d want 1", g_lag, nv); end
         n_checks++; if (lat !== LAT)   begin n_fail++; $display("FAIL delay_latency got %0d want %0d", lat, LAT); end
         n_checks++; if (g_dly !== LW'(g_lag)) begin n_fail++; $display("FAIL delay_dly got %0d want %0d", g_dly, g_lag); end
         n_checks++; if (g_dly !== LW'(e_dly)) begin n_fail++; $display("FAIL delay_dly_model got %0d want %0d", g_dly, e_dly); end
         n_checks++; if (g_pk !== e_pk) begin n_fail++; $display("FAIL delay_peak got %h want %h", g_pk, e_pk); end
         n_checks++; if (!($signed(g_pk) > 0)) begin n_fail++; $display("FAIL delay_peak_pos got %h want >0", g_pk); end
         n_checks++; if (bav !== 1'b1)  begin n_fail++; $display("FAIL delay_busy_at_valid got %b want 1", bav); end
         n_checks++; if (baa !== 1'b0)  begin n_fail++; $display("FAIL delay_busy_after got %b want 0", baa); end
      end
   endtask

   task automatic test_zero_fb();
      int s, nv, lat, e_dly;
      logic [LW-1:0] g_dly;
      logic [AW-1:0] g_pk, e_pk;
      bit g_neg, e_neg, bav, baa;
      g_mode = 0;
      measure(-1, s, nv, lat, g_dly, g_pk, g_neg, bav, baa);
      ref_model(s, e_dly, e_pk, e_neg);
      n_checks++; if (nv !== 1)      begin n_fail++; $display("FAIL zero_npulse got %0d want 1", nv); end
      n_checks++; if (g_dly !== LW'(e_dly)) begin n_fail++; $display("FAIL zero_dly got %0d want %0d", g_dly, e_dly); end
      n_checks++; if (g_pk !== e_pk) begin n_fail++; $display("FAIL zero_peak got %h want %h", g_pk, e_pk); end
   endtask

   task automatic test_inverted();
      int s, nv, lat, e_dly;
      logic [LW-1:0] g_dly;
      logic [AW-1:0] g_pk, e_pk;
      bit g_neg, e_neg, bav, baa;
      g_mode = 2; g_lag = 40;
      repeat (3) step(1'b0, 1'b0);
      measure(-1, s, nv, lat, g_dly, g_pk, g_neg, bav, baa);
      ref_model(s, e_dly, e_pk, e_neg);
      n_checks++; if (nv !== 1)      begin n_fail++; $display("FAIL inv_npulse got %0d want 1", nv); end
      n_checks++; if (g_dly !== LW'(e_dly)) begin n_fail++; $display("FAIL inv_dly_model got %0d want %0d", g_dly, e_dly); end
      n_checks++; if (g_pk !== e_pk) begin n_fail++; $display("FAIL inv_peak got %h want %h", g_pk, e_pk); end
`ifdef DPD_DELAY_EST_ABS_EN
      n_checks++; if (g_dly !== LW'(40)) begin n_fail++; $display("FAIL inv_dly_abs got %0d want 40", g_dly); end
      n_checks++; if (g_neg !== 1'b1) begin n_fail++; $display("FAIL inv_fb_inv got %b want 1", g_neg); end
      n_checks++; if (g_neg !== e_neg) begin n_fail++; $display("FAIL inv_fb_inv_model got %b want %b", g_neg, e_neg); end
`else
      n_checks++; if (g_dly === LW'(40)) begin n_fail++; $display("FAIL inv_dly_signed got %0d want not 40", g_dly); end
`endif
   endtask

   task automatic test_back_to_back();
      int s, nv, lat, e_dly;
      logic [LW-1:0] g_dly;
      logic [AW-1:0] g_pk, e_pk;
      bit g_neg, e_neg, bav, baa;
      g_mode = 1; g_lag = 31;
      repeat (3) step(1'b0, 1'b0);
      measure(100, s, nv, lat, g_dly, g_pk, g_neg, bav, baa);
      ref_model(s, e_dly, e_pk, e_neg);
      n_checks++; if (nv !== 1)     begin n_fail++; $display("FAIL b2b_npulse got %0d want 1", nv); end
      n_checks++; if (lat !== LAT)  begin n_fail++; $display("FAIL b2b_latency got %0d want %0d", lat, LAT); end
      n_checks++; if (g_dly !== LW'(e_dly)) begin n_fail++; $display("FAIL b2b_dly got %0d want %0d", g_dly, e_dly); end
      n_checks++; if (baa !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_after got %b want 0", baa); end
   endtask

   task automatic test_reset_mid();
      int s, nv, lat, e_dly, stray;
      logic [LW-1:0] g_dly;
      logic [AW-1:0] g_pk, e_pk;
      bit g_neg, e_neg, bav, baa;
      g_mode = 1; g_lag = 19;
      step(1'b1, 1'b0);
      for (int i = 1; i < NLAG + 200; i++) step(1'b0, 1'b0);
      n_checks++; if (busy !== 1'b1)   begin n_fail++; $display("FAIL rmid_busy_before got %b want 1", busy); end
      step(1'b0, 1'b1);
      n_checks++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL rmid_busy got %b want 0", busy); end
      n_checks++; if (dly !== '0)      begin n_fail++; $display("FAIL rmid_dly got %0d want 0", dly); end
      n_checks++; if (ref_al_i !== '0) begin n_fail++; $display("FAIL rmid_ref_al_i got %h want 0", ref_al_i); end
      n_checks++; if (ref_al_q !== '0) begin n_fail++; $display("FAIL rmid_ref_al_q got %h want 0", ref_al_q); end
      stray = 0;
      for (int i = 0; i < 200; i++) begin
         step(1'b0, 1'b0);
         if (dly_valid) stray++;
      end
      n_checks++; if (stray !== 0) begin n_fail++; $display("FAIL rmid_stray_valid got %0d want 0", stray); end
      g_lag = 7;
      repeat (3) step(1'b0, 1'b0);
      measure(-1, s, nv, lat, g_dly, g_pk, g_neg, bav, baa);
      ref_model(s, e_dly, e_pk, e_neg);
      n_checks++; if (nv !== 1)      begin n_fail++; $display("FAIL rmid_npulse got %0d want 1", nv); end
      n_checks++; if (g_dly !== LW'(7)) begin n_fail++; $display("FAIL rmid_dly7 got %0d want 7", g_dly); end
      n_checks++; if (g_pk !== e_pk) begin n_fail++; $display("FAIL rmid_peak got %h want %h", g_pk, e_pk); end
   endtask

   task automatic test_ref_al();
      int s, nv, lat, seen_at;
      logic [LW-1:0] g_dly;
      logic [AW-1:0] g_pk;
      bit g_neg, bav, baa;
      g_mode = 1; g_lag = 12;
      repeat (3) step(1'b0, 1'b0);
      measure(-1, s, nv, lat, g_dly, g_pk, g_neg, bav, baa);
      n_checks++; if (g_dly !== LW'(12)) begin n_fail++; $display("FAIL al_dly got %0d want 12", g_dly); end
      g_mode  = 3;
      g_imp   = cyc + 5;
      seen_at = -1;
      for (int i = 0; i < 30; i++) begin
         step(1'b0, 1'b0);
         n_checks++;
         if (ref_al_i !== h_ri[cyc-12] || ref_al_q !== h_rq[cyc-12]) begin
            n_fail++;
            $display("FAIL al_track edge %0d got %h/%h want %h/%h", cyc, ref_al_i, ref_al_q,
                     h_ri[cyc-12], h_rq[cyc-12]);
         end
         if (seen_at < 0 && ref_al_i === 20'sh7FFFF) seen_at = cyc;
      end
      // impulse in the cycle ending at edge g_imp; output register shows it in the cycle ending one edge after it updates
      n_checks++;
      if (seen_at - g_imp + 1 !== 13) begin
         n_fail++;
         $display("FAIL al_impulse_latency got %0d want 13", seen_at - g_imp + 1);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int n = 0; n < MAXC; n++) begin
         h_ri[n] = '0; h_rq[n] = '0; h_fi[n] = '0; h_fq[n] = '0;
      end
      reset = 1'b1; start = 1'b0;
      ref_i = '0; ref_q = '0; fb_i = '0; fb_q = '0;
      test_reset();
      test_delay();
      test_zero_fb();
      test_inverted();
      test_back_to_back();
      test_reset_mid();
      test_ref_al();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
